// File: rtl/lzc_norm_arbiter.sv
// rtl/lzc_norm_arbiter.sv - round-robin shared leading-one detect and normalize unit
module lzc_norm_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*32-1:0]   req_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_data,
    output logic [4:0]            rsp_shift,
    output logic                  rsp_zero
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t          r_state;
    logic [ID_W-1:0] r_rr_ptr;
    logic [ID_W-1:0] r_rsp_id;
    logic [31:0]     r_rsp_data;
    logic [4:0]      r_rsp_shift;
    logic            r_rsp_zero;

    logic            w_found;
    logic [ID_W-1:0] w_grant;
    logic [ID_W-1:0] w_scan;
    logic            w_can_accept;
    logic            w_accept;
    logic [31:0]     w_word;
    logic [5:0]      w_lz;
    logic            w_zero;
    logic [4:0]      w_shift;
    logic [31:0]     w_norm;

    // Modulo-N_REQ increment; N_REQ need not be a power of two.
    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] a);
        if (int'(a) == N_REQ - 1) begin
            return '0;
        end
        return a + ID_W'(1);
    endfunction

    assign rsp_valid    = (r_state == S_FULL);
    assign rsp_id       = r_rsp_id;
    assign rsp_data     = r_rsp_data;
    assign rsp_shift    = r_rsp_shift;
    assign rsp_zero     = r_rsp_zero;

    // Drain and refill in the same cycle, so the stage never bubbles.
    assign w_can_accept = !rsp_valid || rsp_ready;
    assign w_accept     = rst_n && w_found && w_can_accept;

    // Round-robin scan starting at the pointer; first valid requester wins.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_scan  = r_rr_ptr;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_found && req_valid[w_scan]) begin
                w_found = 1'b1;
                w_grant = w_scan;
            end
            w_scan = wrap_inc(w_scan);
        end
    end

    // One-hot ready to the winner only; held low during reset and backpressure.
    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_grant] = 1'b1;
        end
    end

    assign w_word = req_data[32*int'(w_grant) +: 32];

    // Leading-zero count: the highest set bit is the last one written.
    always_comb begin
        w_lz = 6'd32;
        for (int b = 0; b < 32; b++) begin
            if (w_word[b]) begin
                w_lz = 6'(31 - b);
            end
        end
    end

    assign w_zero  = (w_word == 32'd0);
    assign w_shift = w_zero ? 5'd0 : w_lz[4:0];
    assign w_norm  = w_word << w_shift;

    // Result stage FSM, result fields and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_EMPTY;
            r_rr_ptr    <= '0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_rsp_shift <= '0;
            r_rsp_zero  <= 1'b0;
        end else begin
            case (r_state)
                S_EMPTY: if (w_accept) r_state <= S_FULL;
                S_FULL:  if (rsp_ready && !w_accept) r_state <= S_EMPTY;
                default: r_state <= S_EMPTY;
            endcase
            if (w_accept) begin
                r_rsp_id    <= w_grant;
                r_rsp_data  <= w_norm;
                r_rsp_shift <= w_shift;
                r_rsp_zero  <= w_zero;
                r_rr_ptr    <= wrap_inc(w_grant);
            end
        end
    end

endmodule
